mem_fifo_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_fifo_ptr.sv | 24 ++
 rtl/mem_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_mem_fifo_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and types for the FIFO controller and its pointer registers.
package mem_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   ptr_t;
endpackage

// File: rtl/mem_fifo_ptr.sv
// mem_fifo_ptr: circular-buffer pointer with a wrap bit above the address bits.
module mem_fifo_ptr
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [ADDR_W:0] ptr
);
    logic [ADDR_W:0] ptr_q, ptr_d;

    // Plain binary increment carries into the MSB, toggling the wrap bit at DEPTH-1 -> 0.
    always_comb ptr_d = clr ? '0 : inc ? ptr_q + (ADDR_W+1)'(1) : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: circular-buffer FIFO sequencing a dual-port memory with registered read data.
// Define MEM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module mem_fifo_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr_wr,
    output logic [ADDR_W-1:0] mem_addr_rd,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic              push_acc, pop_acc;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_acc),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop_acc),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // Push on full is allowed only alongside an accepted pop; the old word is read before the edge writes.
    always_comb begin
        pop_acc      = pop & ~empty & ~flush;
        push_acc     = push & ~flush & (~full | pop_acc);
        dout_d       = pop_acc ? mem_dout : dout_q;
        dout_valid_d = pop_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign mem_we      = push_acc;
    assign mem_addr_wr = wr_ptr[ADDR_W-1:0];
    assign mem_addr_rd = rd_ptr[ADDR_W-1:0];
    assign mem_din     = din;

`ifdef MEM_FIFO_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = flush ? 1'b0 : overflow_q | (push & full & ~pop_acc);
        underflow_d = flush ? 1'b0 : underflow_q | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: directed vector table plus hand sequences against a behavioural dual-port memory.
module tb_mem_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] dout;
    logic       dout_valid, full, empty;
    logic [3:0] count;
    logic       mem_we;
    logic [2:0] mem_addr_wr, mem_addr_rd;
    logic [3:0] mem_din, mem_dout;
    logic [3:0] mem [8];
`ifdef MEM_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .din         (din),
        .pop         (pop),
        .flush       (flush),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .mem_we      (mem_we),
        .mem_addr_wr (mem_addr_wr),
        .mem_addr_rd (mem_addr_rd),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
`ifdef MEM_FIFO_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always @(posedge clk) if (mem_we) mem[mem_addr_wr] <= mem_din;
    assign mem_dout = mem[mem_addr_rd];

    typedef struct {
        bit p, o, f;
        int d;
        bit we;
        int awr;
        int cnt;
        bit fl, em, dv;
        int dq;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit p, o, f, input int d, input bit we, input int awr,
                       input int cnt, input bit fl, em, dv, input int dq);
        vec_t v;
        v.p = p; v.o = o; v.f = f; v.d = d; v.we = we; v.awr = awr;
        v.cnt = cnt; v.fl = fl; v.em = em; v.dv = dv; v.dq = dq;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit p, o, f, input int d);
        @(negedge clk);
        push = p; pop = o; flush = f; din = 4'(d);
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.p, v.o, v.f, v.d);
        #1;
        chk("mem_we", idx, int'(mem_we), int'(v.we));
        chk("mem_addr_wr", idx, int'(mem_addr_wr), v.awr);
        @(posedge clk);
        #1;
        chk("count", idx, int'(count), v.cnt);
        chk("full", idx, int'(full), int'(v.fl));
        chk("empty", idx, int'(empty), int'(v.em));
        chk("dout_valid", idx, int'(dout_valid), int'(v.dv));
        chk("dout", idx, int'(dout), v.dq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        // fill to full, then a rejected 9th push
        for (int i = 1; i <= 8; i++) add(1, 0, 0, i, 1, i - 1, i, i == 8, 0, 0, 0);
        add(1, 0, 0, 9, 0, 0, 8, 1, 0, 0, 0);
        // drain in order, then a rejected 9th pop
        for (int k = 1; k <= 8; k++) add(0, 1, 0, 0, 0, 0, 8 - k, 0, k == 8, 1, k);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8);
        // wrap: push 5, pop 5, push A..F across address 7 -> 0
        for (int i = 1; i <= 5; i++) add(1, 0, 0, i, 1, i - 1, i, 0, 0, 0, 8);
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, 5, 5 - k, 0, k == 5, 1, k);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 10 + i, 1, (5 + i) % 8, i + 1, 0, 0, 0, 5);
        for (int k = 0; k < 6; k++) add(0, 1, 0, 0, 0, 3, 5 - k, 0, k == 5, 1, 10 + k);
        // full, then simultaneous push+pop of 0xC
        for (int i = 1; i <= 8; i++) add(1, 0, 0, i, 1, (2 + i) % 8, i, i == 8, 0, 0, 15);
        add(1, 1, 0, 12, 1, 3, 8, 1, 0, 1, 1);
        for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 0, 4, 7 - k, 0, k == 7, 1, k < 7 ? k + 2 : 12);
        // empty push+pop: only the push lands
        add(1, 1, 0, 3, 1, 4, 1, 0, 0, 0, 12);
        add(0, 1, 0, 0, 0, 5, 0, 0, 1, 1, 3);
        // flush with count=5 overrides a push
        for (int i = 1; i <= 5; i++) add(1, 0, 0, i, 1, (4 + i) % 8, i, 0, 0, 0, 3);
        add(1, 0, 1, 9, 0, 2, 0, 0, 1, 0, 3);
        add(1, 0, 0, 7, 1, 0, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 7);

        #12;
        chk("rst_count", -1, int'(count), 0);
        chk("rst_empty", -1, int'(empty), 1);
        chk("rst_full", -1, int'(full), 0);
        chk("rst_dout", -1, int'(dout), 0);
        chk("rst_dout_valid", -1, int'(dout_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) apply(vq[i], i);

        // asynchronous reset in the middle of a cycle
        drive(1, 0, 0, 5);
        drive(1, 0, 0, 6);
        drive(0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_count", -2, int'(count), 1);
        chk("pre_rst_dout", -2, int'(dout), 5);
        chk("pre_rst_dv", -2, int'(dout_valid), 1);
        pop = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", -2, int'(count), 0);
        chk("mid_rst_empty", -2, int'(empty), 1);
        chk("mid_rst_dout", -2, int'(dout), 0);
        chk("mid_rst_dv", -2, int'(dout_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_FIFO_ERR_EN
        chk("ovf_reset", -3, int'(overflow), 0);
        chk("udf_reset", -3, int'(underflow), 0);
        drive(0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("udf_set", -3, int'(underflow), 1);
        drive(0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("udf_flush", -3, int'(underflow), 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, i);
        drive(1, 1, 0, 4);
        @(posedge clk);
        #1;
        chk("ovf_pushpop_full", -3, int'(overflow), 0);
        drive(1, 0, 0, 4);
        @(posedge clk);
        #1;
        chk("ovf_set", -3, int'(overflow), 1);
        chk("ovf_count", -3, int'(count), 8);
        drive(0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("ovf_flush", -3, int'(overflow), 0);
        flush = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
